// File: rtl/pwm_multi_channel_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pwm_multi_channel_driver
// Description : NUM_CH-channel PWM driver at LEVEL_W-bit resolution. One shared
//               period counter runs either edge-aligned (up) or centre-aligned
//               (up/down). Levels are written into per-channel shadow registers
//               and committed to the active registers only at period boundaries,
//               so no output changes shape mid-period.
//               Optional clock prescaler: define PWM_PRESCALE_EN.
// Revision    : 1.0 - initial parametrised release
//------------------------------------------------------------------------------
module pwm_multi_channel_driver #(
  parameter int NUM_CH  = 8,
  parameter int LEVEL_W = 3,
  parameter int ADDR_W  = 3,
  parameter int ALIGN   = 0
`ifdef PWM_PRESCALE_EN
  ,
  parameter int PRESCALE_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [LEVEL_W-1:0]    wr_level,
`ifdef PWM_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_start
);

  // Top of the count range; 2^LEVEL_W-1 is reserved as the "always high" level.
  localparam logic [LEVEL_W-1:0] c_MAX = {{(LEVEL_W-1){1'b1}}, 1'b0};
  localparam logic [LEVEL_W-1:0] c_ONE = {{(LEVEL_W-1){1'b0}}, 1'b1};

  // Counter direction state (only meaningful in centre-aligned mode).
  localparam logic [0:0] c_DIR_UP   = 1'b0;
  localparam logic [0:0] c_DIR_DOWN = 1'b1;

  logic [LEVEL_W-1:0] r_cnt;
  logic [0:0]         r_dir;
  logic [LEVEL_W-1:0] w_cnt_nxt;
  logic [0:0]         w_dir_nxt;
  logic               w_wrap;     // cnt returns to 0 on this edge
  logic               w_commit;   // active <= shadow on this edge
  logic               w_tick;     // cnt is allowed to advance on this edge
  logic               w_first;    // first clk cycle of the current tick slot

`ifdef PWM_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_tick_cnt;

  // Divide clk by prescale+1; held clear while disabled so an enable starts a fresh slot.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  // >= rather than == so a prescale decrease cannot strand the counter above it.
  assign w_tick  = (r_tick_cnt >= prescale);
  assign w_first = (r_tick_cnt == '0);
`else
  assign w_tick  = 1'b1;
  assign w_first = 1'b1;
`endif

  // Period counter and direction state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dir <= c_DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // Next counter value/direction and detection of the wrap back to 0.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    if (!enable) begin
      w_cnt_nxt = '0;
      w_dir_nxt = c_DIR_UP;
    end else if (w_tick) begin
      if (ALIGN == 0) begin
        if (r_cnt == c_MAX) begin
          w_cnt_nxt = '0;
          w_wrap    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end else if (r_dir == c_DIR_UP) begin
        if (r_cnt == c_MAX) begin
          w_cnt_nxt = r_cnt - c_ONE;
          // A range of 0..1 has no down leg: the turn-around is also the wrap.
          if (r_cnt == c_ONE) begin
            w_wrap = 1'b1;
          end else begin
            w_dir_nxt = c_DIR_DOWN;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end else begin
        w_cnt_nxt = r_cnt - c_ONE;
        if (r_cnt == c_ONE) begin
          w_dir_nxt = c_DIR_UP;
          w_wrap    = 1'b1;
        end
      end
    end
  end

  // While disabled, levels are committed every edge so they take effect at once.
  assign w_commit = ~enable | w_wrap;

  // Period marker: first clk cycle at cnt==0 on the upward leg.
  always_comb begin
    period_start = enable & ~reset & w_first & (r_cnt == '0) &
                   ((ALIGN == 0) || (r_dir == c_DIR_UP));
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      logic [LEVEL_W-1:0] r_shadow;
      logic [LEVEL_W-1:0] r_active;
      logic               w_hit;

      // Addresses >= NUM_CH never match any channel, so such writes are dropped.
      assign w_hit = wr_en & (wr_addr == ADDR_W'(k));

      // Shadow capture and boundary commit; a write on a commit edge goes straight through.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_shadow <= '0;
          r_active <= '0;
        end else begin
          if (w_hit) begin
            r_shadow <= wr_level;
          end
          if (w_commit) begin
            r_active <= w_hit ? wr_level : r_shadow;
          end
        end
      end

      assign pwm_out[k] = enable & ~reset & (r_cnt < r_active);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel_driver.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_pwm_multi_channel_driver
// Description : Directed self-checking bench for pwm_multi_channel_driver.
//               Three instances: defaults (edge, 8 ch), centre-aligned, 6 ch.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pwm_multi_channel_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, en_c, en_s;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_level;
  logic [7:0] pwm_a, pwm_c;
  logic [5:0] pwm_s;
  logic       ps_a, ps_c, ps_s;
`ifdef PWM_PRESCALE_EN
  logic [7:0] prescale;
  logic [7:0] prescale_off;
`endif

  int checks   = 0;
  int failures = 0;
  int lv[8];

  always #5 clk = ~clk;

  pwm_multi_channel_driver #(.NUM_CH(8), .LEVEL_W(3), .ADDR_W(3), .ALIGN(0)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_level(wr_level),
`ifdef PWM_PRESCALE_EN
    .prescale(prescale),
`endif
    .pwm_out(pwm_a), .period_start(ps_a));

  pwm_multi_channel_driver #(.NUM_CH(8), .LEVEL_W(3), .ADDR_W(3), .ALIGN(1)) dut_c (
    .clk(clk), .reset(reset), .enable(en_c), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_level(wr_level),
`ifdef PWM_PRESCALE_EN
    .prescale(prescale_off),
`endif
    .pwm_out(pwm_c), .period_start(ps_c));

  pwm_multi_channel_driver #(.NUM_CH(6), .LEVEL_W(3), .ADDR_W(3), .ALIGN(0)) dut_s (
    .clk(clk), .reset(reset), .enable(en_s), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_level(wr_level),
`ifdef PWM_PRESCALE_EN
    .prescale(prescale_off),
`endif
    .pwm_out(pwm_s), .period_start(ps_s));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge-mode outputs for counter value c given the expected active levels.
  function automatic logic [7:0] exp_edge(input int c);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = (c < lv[k]);
    return r;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // One dut_a cycle at counter value c, with an optional write presented for the next edge.
  task automatic cyc_a(input bit w, input int a, input int l, input int c, input string tag);
    wr_en = w; wr_addr = 3'(a); wr_level = 3'(l);
    #1;
    chk({tag, "_pwm"}, pwm_a, exp_edge(c));
    chk({tag, "_ps"}, ps_a, (c == 0));
    clk_step();
    wr_en = 1'b0;
  endtask

  // A full 7-cycle dut_a period with up to two writes (cycle index -1 = none).
  task automatic period_a(input int c1, input int ch1, input int l1,
                          input int c2, input int ch2, input int l2, input string tag);
    for (int c = 0; c < 7; c++) begin
      if (c == c1)      cyc_a(1'b1, ch1, l1, c, tag);
      else if (c == c2) cyc_a(1'b1, ch2, l2, c, tag);
      else              cyc_a(1'b0, 0, 0, c, tag);
    end
  endtask

  task automatic cyc_s(input int c, input int lvl3, input string tag);
    #1;
    chk({tag, "_pwm"}, pwm_s, {2'b00, (c < lvl3), 3'b000});
    chk({tag, "_ps"}, ps_s, (c == 0));
    clk_step();
  endtask

  task automatic wr_disabled(input int a, input int l);
    wr_en = 1'b1; wr_addr = 3'(a); wr_level = 3'(l);
    clk_step();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en_a = 1'b0; en_c = 1'b0; en_s = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_level = '0;
`ifdef PWM_PRESCALE_EN
    prescale = 8'd0; prescale_off = 8'd0;
`endif
    for (int k = 0; k < 8; k++) lv[k] = 0;
    repeat (2) clk_step();

    // Outputs stay low while reset is high, even with enable asserted.
    en_a = 1'b1;
    #1;
    chk("reset_pwm", pwm_a, 8'h00);
    chk("reset_ps", ps_a, 1'b0);
    en_a = 1'b0;
    clk_step();
    reset = 1'b0;

    // Disabled writes apply immediately but outputs remain low.
    wr_disabled(0, 3);
    wr_disabled(6, 4);
    lv[0] = 3; lv[6] = 4;
    #1;
    chk("dis_pwm", pwm_a, 8'h00);
    chk("dis_ps", ps_a, 1'b0);

    // Period begins in the first enabled cycle; ch0 3/7, ch6 4/7.
    en_a = 1'b1;
    period_a(-1, 0, 0, -1, 0, 0, "p1");
    period_a(-1, 0, 0, -1, 0, 0, "p2");
    period_a(-1, 0, 0, -1, 0, 0, "p3");

    // Running writes ch5=7, ch6=0: no change until the next period.
    period_a(0, 5, 7, 1, 6, 0, "p_wr");
    lv[5] = 7; lv[6] = 0;
    period_a(2, 2, 2, -1, 0, 0, "p_new");
    lv[2] = 2;
    // Mid-period write at cnt=3 keeps 2 high cycles this period.
    period_a(3, 2, 5, -1, 0, 0, "p_mid");
    lv[2] = 5;
    // Write exactly at cnt==MAX commits straight through.
    period_a(6, 2, 1, -1, 0, 0, "p_wt");
    lv[2] = 1;
    period_a(-1, 0, 0, -1, 0, 0, "p_after_wt");
    en_a = 1'b0;

`ifdef PWM_PRESCALE_EN
    // prescale=2: period of 21 clk, ch0=1 high for 3 clk, one-clk period_start.
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    prescale = 8'd2;
    wr_disabled(0, 1);
    en_a = 1'b1;
    for (int i = 0; i < 42; i++) begin
      #1;
      chk("pre_pwm", pwm_a, {7'b0, (((i % 21) / 3) < 1)});
      chk("pre_ps", ps_a, ((i % 21) == 0));
      clk_step();
    end
    en_a = 1'b0;
    prescale = 8'd0;
`endif

    // Centre-aligned: ch1=3 gives 5 high cycles around cnt=0, period 12.
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    wr_disabled(1, 3);
    en_c = 1'b1;
    for (int i = 0; i < 36; i++) begin
      int p, cn, lvl;
      p   = i % 12;
      cn  = (p <= 6) ? p : 12 - p;
      lvl = (i < 24) ? 3 : 1;
      // Write at the cnt=1 downward cycle: commits on the wrap edge.
      if (i == 23) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_level = 3'd1;
      end
      #1;
      chk("ctr_pwm", pwm_c, {6'b0, (cn < lvl), 1'b0});
      chk("ctr_ps", ps_c, (p == 0));
      clk_step();
      wr_en = 1'b0;
    end
    en_c = 1'b0;

    // NUM_CH=6: writes to addresses 6 and 7 are dropped.
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    wr_disabled(3, 5);
    wr_disabled(7, 6);
    wr_disabled(6, 6);
    en_s = 1'b1;
    for (int c = 0; c < 7; c++) cyc_s(c, 5, "s_oob");
    for (int c = 0; c < 4; c++) cyc_s(c, 5, "s_pre_rst");
    // Reset at cnt=4 (ch3 would be high there without gating).
    reset = 1'b1;
    #1;
    chk("s_rst_pwm", pwm_s, 6'h00);
    chk("s_rst_ps", ps_s, 1'b0);
    clk_step();
    reset = 1'b0;
    // Counter back at 0, all levels cleared.
    for (int c = 0; c < 7; c++) cyc_s(c, 0, "s_post_rst");
    en_s = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_multi_channel_driver.md
Name: pwm_multi_channel_driver

Overview:
Parametrised successor to the team's 3-bit/8-channel PWM driver. Drives NUM_CH channels at LEVEL_W-bit resolution from one free-running period counter. Edge-aligned or centre-aligned, selected by parameter. Level writes go to per-channel shadow registers and are committed glitch-free at period boundaries. Sits between the pin-level register/SPI write front-end and the io_out pins.

Parameters:
NUM_CH, 8, number of PWM channels (1..64)
LEVEL_W, 3, level and counter width in bits (2..12); MAX = 2^LEVEL_W - 2
ADDR_W, 3, channel address width; must satisfy 2^ADDR_W >= NUM_CH
ALIGN, 0, 0 = edge-aligned (up counter), 1 = centre-aligned (up/down counter)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = counter runs; 0 = counter held at 0, all outputs low
wr_en  in  1  level write strobe, sampled on posedge
wr_addr  in  ADDR_W  target channel index
wr_level  in  LEVEL_W  new level for the target channel
pwm_out  out  NUM_CH  PWM outputs, bit k = channel k
period_start  out  1  high during the first cycle of each PWM period

Behaviour:
- Reset (sync, active-high): cnt=0, dir=up, all shadow[k]=0, all active[k]=0. pwm_out=0 and period_start=0 while reset is high. Reset mid-period aborts the period immediately.
- Edge mode (ALIGN=0): cnt runs 0,1,..,MAX, then wraps to 0. Period = MAX+1 cycles (7 at LEVEL_W=3).
- Centre mode (ALIGN=1): cnt runs up 0..MAX, then down MAX-1..1, then back to 0. Period = 2*MAX cycles (12 at LEVEL_W=3).
- Output decode: pwm_out[k] = enable & (cnt < active[k]), computed combinationally from registered state only; there is no input-to-output combinational path.
  - Level 0: output always low.
  - Level 2^LEVEL_W-1: output always high.
  - Edge mode: level L gives L high cycles per period.
  - Centre mode: level L gives 2L-1 high cycles per period, centred on cnt=0.
- Writes: when wr_en=1 and wr_addr<NUM_CH, shadow[wr_addr] <= wr_level on that edge. Writes with wr_addr>=NUM_CH are ignored. Writes are never stalled; a later write to the same channel overwrites an earlier one.
- Commit: on the edge where cnt moves to 0, every active[k] <= shadow[k].
  - Edge mode: that edge is at cnt==MAX.
  - Centre mode: that edge is going down at cnt==1; with MAX==1, every edge where cnt returns to 0.
  - Simultaneous write and commit on the same edge: active[wr_addr] takes wr_level directly (write-through); the other channels take their shadow values.
  - Result: a new level takes effect at the start of the next period, never mid-period.
- Disabled (enable=0):
  - cnt forced to 0 and dir forced to up.
  - active[k] <= shadow[k] on every edge (same write-through rule), so levels apply immediately.
  - pwm_out=0, period_start=0.
- Enable transition 0->1: a period begins with cnt=0 in the first enabled cycle.
- period_start = enable & ~reset & (cnt==0); in centre mode additionally dir==up. Exactly one cycle per period.
- All arithmetic is unsigned at LEVEL_W bits. cnt never exceeds MAX.

Optional Feature:
Macro PWM_PRESCALE_EN.
- Defined: adds parameter PRESCALE_W (default 8) and input port prescale [PRESCALE_W]. An internal tick counter lets cnt advance only once every prescale+1 clk cycles.
  - Commit, period_start and the disabled-hold rules apply per tick.
  - period_start lasts one clk cycle, namely the first cycle with cnt==0.
  - The tick counter clears on reset and while enable=0.
  - prescale=0 behaves identically to the macro being undefined.
- Undefined: no prescale port; cnt advances every clk cycle.

Test Plan:
- Defaults: reset, then enable=1 and write ch0=3 while disabled. Expect pwm_out[0] high for 3 of every 7 cycles, and period_start pulsing every 7 cycles starting in the first enabled cycle.
- Defaults, running: write ch5=7 and ch6=0. Expect ch5 constantly high and ch6 constantly low from the next period start. Check that no output changes mid-period.
- Mid-period write: ch2=2 active, write ch2=5 at cnt=3. Expect the current period to keep 2 high cycles and the next period to show 5. Then write exactly at cnt==MAX: expect the new value to apply in the very next period (write-through).
- ALIGN=1, LEVEL_W=3: ch1=3. Expect period 12 with ch1 high for 5 consecutive cycles (cnt 2,1,0,1,2 across the boundary), and period_start only at cnt=0 going up.
- Boundaries: write with wr_addr=7 when NUM_CH=6, expect no state change. Assert reset at cnt=4, expect cnt=0, pwm_out=0 and all levels 0 on the next cycle.
- PWM_PRESCALE_EN, prescale=2: ch0=1. Expect a period of 21 clk cycles with pwm_out[0] high for 3 consecutive clk cycles, and period_start high for 1 clk cycle per period.
